gram_dfii_wb_csr: RTL

Wishbone classic responder implementing the DFII software-control register bank at word base 0x2400 (byte 0x9000).
Firmware and the bench drive DDR3 init (reset_n, CKE, MRS, ZQCL) through it before handing control to the hardware controller via SEL.
It holds the control and command registers, and emits a single-cycle DFI command on each issue strobe.
It captures one DFI read beat for readback.

---
 rtl/gram_dfii_pkg.sv | 57 +++++
 rtl/gram_dfii_cmd_pulse.sv | 45 ++++
 rtl/gram_dfii_wb_csr.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/gram_dfii_pkg.sv
// Shared definitions for the DFII software-control register bank:
// register offsets, CONTROL/COMMAND bit positions and the DFI command beat.
package gram_dfii_pkg;

    typedef enum logic [2:0] {
        REG_CONTROL  = 3'd0,
        REG_COMMAND  = 3'd1,
        REG_ISSUE    = 3'd2,
        REG_ADDRESS  = 3'd3,
        REG_BADDRESS = 3'd4,
        REG_WRDATA   = 3'd5,
        REG_RDDATA   = 3'd6
    } dfii_reg_e;

    localparam int unsigned NUM_REGS = 7;

    localparam int CTRL_SEL     = 0;
    localparam int CTRL_CKE     = 1;
    localparam int CTRL_ODT     = 2;
    localparam int CTRL_RESET_N = 3;
    localparam int CTRL_W       = 4;

    localparam int CMD_CS   = 0;
    localparam int CMD_WE   = 1;
    localparam int CMD_CAS  = 2;
    localparam int CMD_RAS  = 3;
    localparam int CMD_WREN = 4;
    localparam int CMD_RDEN = 5;
    localparam int CMD_W    = 6;

    typedef struct packed {
        logic cs_n;
        logic ras_n;
        logic cas_n;
        logic we_n;
        logic wrdata_en;
        logic rddata_en;
    } dfi_cmd_t;

    localparam dfi_cmd_t DFI_CMD_IDLE = '{
        cs_n: 1'b1, ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b1,
        wrdata_en: 1'b0, rddata_en: 1'b0
    };

    // COMMAND register bits are active-high; the DFI strobes are active-low.
    function automatic dfi_cmd_t cmd_decode(input logic [CMD_W-1:0] cmd);
        dfi_cmd_t beat;
        beat.cs_n      = ~cmd[CMD_CS];
        beat.ras_n     = ~cmd[CMD_RAS];
        beat.cas_n     = ~cmd[CMD_CAS];
        beat.we_n      = ~cmd[CMD_WE];
        beat.wrdata_en = cmd[CMD_WREN];
        beat.rddata_en = cmd[CMD_RDEN];
        return beat;
    endfunction

endpackage

// File: rtl/gram_dfii_cmd_pulse.sv
// One-shot DFI command generator: a fire strobe turns the COMMAND bits into
// exactly one registered command beat; every other cycle the bus idles.
module gram_dfii_cmd_pulse
    import gram_dfii_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fire_i,
    input  logic [CMD_W-1:0]  cmd_i,
    output logic              cs_n_o,
    output logic              ras_n_o,
    output logic              cas_n_o,
    output logic              we_n_o,
    output logic              wrdata_en_o,
    output logic              rddata_en_o
);

    dfi_cmd_t beat_d;
    dfi_cmd_t beat_q;

    always_comb begin
        // NOTE: assign a default before any condition so no path leaves beat_d unassigned (no latch).
        beat_d = DFI_CMD_IDLE;
        if (fire_i) begin
            beat_d = cmd_decode(cmd_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q <= DFI_CMD_IDLE;
        end else begin
            // NOTE: non-blocking assignment so every flop samples pre-edge values.
            beat_q <= beat_d;
        end
    end

    assign cs_n_o      = beat_q.cs_n;
    assign ras_n_o     = beat_q.ras_n;
    assign cas_n_o     = beat_q.cas_n;
    assign we_n_o      = beat_q.we_n;
    assign wrdata_en_o = beat_q.wrdata_en;
    assign rddata_en_o = beat_q.rddata_en;

endmodule

// File: rtl/gram_dfii_wb_csr.sv
// Wishbone classic responder for the DFII software-control registers used by
// firmware to sequence DDR3 init before handing DFI to the hardware controller.
module gram_dfii_wb_csr
    import gram_dfii_pkg::*;
#(
    parameter logic [31:0] BASE_ADR = 32'h2400,
    parameter int          ADDR_W   = 14,
    parameter int          BANK_W   = 3,
    parameter int          DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       wb_adr,
    input  logic [31:0]       wb_dat_w,
    output logic [31:0]       wb_dat_r,
    input  logic [3:0]        wb_sel,
    input  logic              wb_cyc,
    input  logic              wb_stb,
    input  logic              wb_we,
    output logic              wb_ack,
    output logic              dfii_sel,
    output logic              dfi_cke,
    output logic              dfi_odt,
    output logic              dfi_reset_n,
    output logic              dfi_cs_n,
    output logic              dfi_ras_n,
    output logic              dfi_cas_n,
    output logic              dfi_we_n,
    output logic [ADDR_W-1:0] dfi_address,
    output logic [BANK_W-1:0] dfi_bank,
    output logic              dfi_wrdata_en,
    output logic [DATA_W-1:0] dfi_wrdata,
    output logic              dfi_rddata_en,
    input  logic [DATA_W-1:0] dfi_rddata,
    input  logic              dfi_rddata_valid
);

    // Reset asserts asynchronously but releases two edges later, clean to clk.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    logic              wb_ack_q;
    logic [31:0]       wb_dat_r_q;
    logic [31:0]       rd_data_d;
    logic [CTRL_W-1:0] control_q;
    logic [CMD_W-1:0]  command_q;
    logic [ADDR_W-1:0] address_q;
    logic [BANK_W-1:0] baddress_q;
    logic [DATA_W-1:0] wrdata_q;
    logic [DATA_W-1:0] rddata_q;

    logic [31:0] offset;
    logic        in_range;
    logic        req;
    logic        wr_en;
    logic        issue_fire;

    // Offset arithmetic wraps, so addresses below BASE_ADR fall out of range too.
    assign offset   = wb_adr - BASE_ADR;
    assign in_range = offset < 32'(NUM_REGS);
    assign req      = wb_cyc & wb_stb & ~wb_ack_q;
    assign wr_en    = req & wb_we & in_range & (wb_sel == 4'hF);

    assign issue_fire = wr_en & (offset[2:0] == REG_ISSUE) & wb_dat_w[0]
                      & ~control_q[CTRL_SEL];

    always_comb begin
        rd_data_d = '0;
        if (in_range) begin
            case (offset[2:0])
                REG_CONTROL:  rd_data_d = 32'(control_q);
                REG_COMMAND:  rd_data_d = 32'(command_q);
                REG_ADDRESS:  rd_data_d = 32'(address_q);
                REG_BADDRESS: rd_data_d = 32'(baddress_q);
                REG_WRDATA:   rd_data_d = 32'(wrdata_q);
                REG_RDDATA:   rd_data_d = 32'(rddata_q);
                default:      rd_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            wb_ack_q   <= 1'b0;
            wb_dat_r_q <= '0;
        end else begin
            wb_ack_q   <= req;
            wb_dat_r_q <= (req && !wb_we) ? rd_data_d : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            control_q  <= '0;
            command_q  <= '0;
            address_q  <= '0;
            baddress_q <= '0;
            wrdata_q   <= '0;
            rddata_q   <= '0;
        end else begin
            if (wr_en) begin
                case (offset[2:0])
                    REG_CONTROL:  control_q  <= wb_dat_w[CTRL_W-1:0];
                    REG_COMMAND:  command_q  <= wb_dat_w[CMD_W-1:0];
                    REG_ADDRESS:  address_q  <= wb_dat_w[ADDR_W-1:0];
                    REG_BADDRESS: baddress_q <= wb_dat_w[BANK_W-1:0];
                    REG_WRDATA:   wrdata_q   <= DATA_W'(wb_dat_w);
                    default:      ;
                endcase
            end
            // A same-edge Wishbone read of RDDATA still sees the old capture.
            if (dfi_rddata_valid) begin
                rddata_q <= dfi_rddata;
            end
        end
    end

    gram_dfii_cmd_pulse u_cmd_pulse (
        .clk         (clk),
        .rst_n       (rst_int_n),
        .fire_i      (issue_fire),
        .cmd_i       (command_q),
        .cs_n_o      (dfi_cs_n),
        .ras_n_o     (dfi_ras_n),
        .cas_n_o     (dfi_cas_n),
        .we_n_o      (dfi_we_n),
        .wrdata_en_o (dfi_wrdata_en),
        .rddata_en_o (dfi_rddata_en)
    );

    assign wb_ack      = wb_ack_q;
    assign wb_dat_r    = wb_dat_r_q;
    assign dfii_sel    = control_q[CTRL_SEL];
    assign dfi_cke     = control_q[CTRL_CKE];
    assign dfi_odt     = control_q[CTRL_ODT];
    assign dfi_reset_n = control_q[CTRL_RESET_N];
    assign dfi_address = address_q;
    assign dfi_bank    = baddress_q;
    assign dfi_wrdata  = wrdata_q;

endmodule
